// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan driver.
// Segment codes are gfedcba, active-high.
package seg_pkg;

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        DRIVE = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [3:0] PHASE_FIRST = 4'b1000;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;

    // True when exactly one bit is set; clearing the lowest set bit must leave zero.
    function automatic logic is_onehot(input logic [3:0] p);
        return (p != 4'b0000) && ((p & (p - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to seven-segment decoder; non-decimal codes show a dash.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed display driver following an external one-hot ring phase,
// with anti-ghosting blanking, frame-aligned value commit and a sticky phase fault.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  phase,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    input  logic [3:0]  load_dp,
    output logic        load_ready,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        err
);

    localparam logic [3:0] BLANK_LAST = 4'(BLANK_CYCLES - 1);

    state_t      state;
    logic [3:0]  blank_cnt;
    logic [3:0]  phase_q;
    logic [15:0] disp_data;
    logic [3:0]  disp_dp;
    logic [15:0] pend_data;
    logic [3:0]  pend_dp;
    logic        pend_full;

    logic        phase_changed;
    logic        commit;
    logic [1:0]  digit_idx;
    logic [3:0]  digit_bcd;
    logic [6:0]  digit_seg;
    logic        drive;

    assign phase_changed = (phase != phase_q);
    assign commit        = phase_changed && (phase == PHASE_FIRST) && pend_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= BLANK;
            blank_cnt <= 4'd0;
            phase_q   <= 4'b0000;
            disp_data <= 16'h0000;
            disp_dp   <= 4'b0000;
            pend_data <= 16'h0000;
            pend_dp   <= 4'b0000;
            pend_full <= 1'b0;
        end else begin
            phase_q <= phase;

            // FAULT is absorbing; an illegal phase outranks an ordinary change.
            if (state != FAULT) begin
                if (!is_onehot(phase)) begin
                    state <= FAULT;
                end else if (phase_changed) begin
                    state     <= BLANK;
                    blank_cnt <= 4'd0;
                end else if (state == BLANK) begin
                    if (blank_cnt == BLANK_LAST) state <= DRIVE;
                    else                         blank_cnt <= blank_cnt + 4'd1;
                end
            end

            // Commit needs a full slot and a transfer needs an empty one, so they never coincide.
            if (commit) begin
                disp_data <= pend_data;
                disp_dp   <= pend_dp;
                pend_full <= 1'b0;
            end else if (load_valid && !pend_full) begin
                pend_data <= load_data;
                pend_dp   <= load_dp;
                pend_full <= 1'b1;
            end
        end
    end

    // Phase bit 3 is the leftmost digit, which holds load_data[3:0].
    always_comb begin
        case (phase_q)
            4'b1000: digit_idx = 2'd0;
            4'b0100: digit_idx = 2'd1;
            4'b0010: digit_idx = 2'd2;
            4'b0001: digit_idx = 2'd3;
            default: digit_idx = 2'd0;
        endcase
    end

    assign digit_bcd = disp_data[{digit_idx, 2'b00} +: 4];

    bcd_to_seg u_dec (
        .bcd (digit_bcd),
        .seg (digit_seg)
    );

    assign drive      = (state == DRIVE);
    assign an         = drive ? phase_q : 4'b0000;
    assign seg        = drive ? digit_seg : 7'h00;
    assign dp         = drive ? disp_dp[digit_idx] : 1'b0;
    assign err        = (state == FAULT);
    assign load_ready = !pend_full;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: stimulus pushes hand-computed per-cycle
// expectations into a queue, a negedge monitor pops and compares them.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  phase = 4'b1000;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = 16'h0000;
    logic [3:0]  load_dp = 4'b0000;
    logic        load_ready;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        err;

    int checks = 0;
    int errors = 0;
    int step_no = 0;

    typedef struct {
        logic        chk;
        logic [13:0] v;    // {an, seg, dp, err, load_ready}
        int          id;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    seg_scan_driver #(.BLANK_CYCLES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .phase      (phase),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_dp    (load_dp),
        .load_ready (load_ready),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .err        (err)
    );

    // Drive one cycle of inputs and record what the outputs must show in that cycle.
    task automatic step(input logic rst, input logic [3:0] ph, input logic lv,
                        input logic [15:0] ld, input logic [3:0] ldp, input logic chk,
                        input logic [3:0] e_an, input logic [6:0] e_seg,
                        input logic e_dp, input logic e_err, input logic e_rdy);
        exp_t e;
        @(posedge clk);
        #1;
        reset      = rst;
        phase      = ph;
        load_valid = lv;
        load_data  = ld;
        load_dp    = ldp;
        e.chk = chk;
        e.v   = {e_an, e_seg, e_dp, e_err, e_rdy};
        e.id  = step_no;
        exp_q.push_back(e);
        step_no++;
    endtask

    // Hold a new phase four cycles: previous digit still lit, two blank cycles, new digit lit.
    task automatic hold4(input logic [3:0] ph, input logic [3:0] p_an, input logic [6:0] p_seg,
                         input logic p_dp, input logic [6:0] n_seg, input logic n_dp,
                         input logic r_first, input logic r_rest, input logic lv,
                         input logic [15:0] ld, input logic [3:0] ldp);
        step(1'b0, ph, lv,   ld,       ldp,  1'b1, p_an,    p_seg, p_dp, 1'b0, r_first);
        step(1'b0, ph, 1'b0, 16'h0000, 4'h0, 1'b1, 4'b0000, 7'h00, 1'b0, 1'b0, r_rest);
        step(1'b0, ph, 1'b0, 16'h0000, 4'h0, 1'b1, 4'b0000, 7'h00, 1'b0, 1'b0, r_rest);
        step(1'b0, ph, 1'b0, 16'h0000, 4'h0, 1'b1, ph,      n_seg, n_dp, 1'b0, r_rest);
    endtask

    task automatic plain(input logic [3:0] ph, input logic [3:0] e_an, input logic [6:0] e_seg,
                         input logic e_err);
        step(1'b0, ph, 1'b0, 16'h0000, 4'h0, 1'b1, e_an, e_seg, 1'b0, e_err, 1'b1);
    endtask

    initial begin : monitor
        exp_t        e;
        logic [13:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    act = {an, seg, dp, err, load_ready};
                    checks++;
                    if (act !== e.v) begin
                        errors++;
                        $display("FAIL step%0d an/seg/dp/err/rdy: got %b/%h/%b/%b/%b expected %b/%h/%b/%b/%b",
                                 e.id, act[13:10], act[9:3], act[2], act[1], act[0],
                                 e.v[13:10], e.v[9:3], e.v[2], e.v[1], e.v[0]);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        // Reset, then 1000 held: two blank cycles, then digit 0 shows "0".
        step(1'b1, 4'b1000, 1'b0, 16'h0000, 4'h0, 1'b0, 4'b0000, 7'h00, 1'b0, 1'b0, 1'b1);
        step(1'b1, 4'b1000, 1'b0, 16'h0000, 4'h0, 1'b1, 4'b0000, 7'h00, 1'b0, 1'b0, 1'b1);
        plain(4'b1000, 4'b0000, 7'h00, 1'b0);
        plain(4'b1000, 4'b0000, 7'h00, 1'b0);
        plain(4'b1000, 4'b0000, 7'h00, 1'b0);
        plain(4'b1000, 4'b1000, 7'h3F, 1'b0);
        plain(4'b1000, 4'b1000, 7'h3F, 1'b0);

        // Load 1234 (dp on digit 0) while digit 2 is selected; commit at the 1000 change.
        hold4(4'b0100, 4'b1000, 7'h3F, 1'b0, 7'h3F, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 4'h0);
        hold4(4'b0010, 4'b0100, 7'h3F, 1'b0, 7'h3F, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1234, 4'b0001);
        hold4(4'b0001, 4'b0010, 7'h3F, 1'b0, 7'h3F, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0);
        hold4(4'b1000, 4'b0001, 7'h3F, 1'b0, 7'h66, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 4'h0);

        // Load 00A0; old value keeps scanning (3,2,1) until the next frame start.
        hold4(4'b0100, 4'b1000, 7'h66, 1'b1, 7'h4F, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00A0, 4'b0000);
        hold4(4'b0010, 4'b0100, 7'h4F, 1'b0, 7'h5B, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0);
        hold4(4'b0001, 4'b0010, 7'h5B, 1'b0, 7'h06, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0);
        hold4(4'b1000, 4'b0001, 7'h06, 1'b0, 7'h3F, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 4'h0);
        hold4(4'b0100, 4'b1000, 7'h3F, 1'b0, 7'h40, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 4'h0);
        hold4(4'b0010, 4'b0100, 7'h40, 1'b0, 7'h3F, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 4'h0);
        hold4(4'b0001, 4'b0010, 7'h3F, 1'b0, 7'h3F, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 4'h0);

        // Load 5678 on the 1000 change with the slot empty: deferred a whole frame.
        hold4(4'b1000, 4'b0001, 7'h3F, 1'b0, 7'h3F, 1'b0, 1'b1, 1'b0, 1'b1, 16'h5678, 4'b0000);
        hold4(4'b0100, 4'b1000, 7'h3F, 1'b0, 7'h40, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0);
        hold4(4'b0010, 4'b0100, 7'h40, 1'b0, 7'h3F, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0);
        hold4(4'b0001, 4'b0010, 7'h3F, 1'b0, 7'h3F, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0);
        hold4(4'b1000, 4'b0001, 7'h3F, 1'b0, 7'h7F, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 4'h0);

        // Phase toggling every cycle keeps restarting the blanking.
        plain(4'b0100, 4'b1000, 7'h7F, 1'b0);
        for (int i = 0; i < 10; i++)
            plain((i % 2 == 0) ? 4'b1000 : 4'b0100, 4'b0000, 7'h00, 1'b0);
        plain(4'b0100, 4'b0000, 7'h00, 1'b0);
        plain(4'b0100, 4'b0000, 7'h00, 1'b0);
        plain(4'b0100, 4'b0100, 7'h07, 1'b0);

        // Two-hot phase faults; legal phases do not clear it, reset does.
        plain(4'b0110, 4'b0100, 7'h07, 1'b0);
        plain(4'b1000, 4'b0000, 7'h00, 1'b1);
        plain(4'b0100, 4'b0000, 7'h00, 1'b1);
        plain(4'b0010, 4'b0000, 7'h00, 1'b1);
        plain(4'b0001, 4'b0000, 7'h00, 1'b1);
        step(1'b1, 4'b1000, 1'b0, 16'h0000, 4'h0, 1'b1, 4'b0000, 7'h00, 1'b0, 1'b1, 1'b1);
        plain(4'b1000, 4'b0000, 7'h00, 1'b0);
        plain(4'b1000, 4'b0000, 7'h00, 1'b0);
        plain(4'b1000, 4'b0000, 7'h00, 1'b0);
        plain(4'b1000, 4'b1000, 7'h3F, 1'b0);

        // All-zero phase is also a fault.
        plain(4'b0000, 4'b1000, 7'h3F, 1'b0);
        plain(4'b1000, 4'b0000, 7'h00, 1'b1);
        plain(4'b1000, 4'b0000, 7'h00, 1'b1);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
